// File: rtl/sys_defs_pkg.sv
// sys_defs: shared sizing macros and reservation-station slot-state type
`ifndef SYS_DEFS_PKG_SV
`define SYS_DEFS_PKG_SV
`define RS_SIZE 8
`define ROB_SIZE 32
package sys_defs;
  typedef enum logic [1:0] {RS_FREE, RS_WAIT, RS_READY} RS_SLOT_STATE;
endpackage
`endif

// File: rtl/rs_ctrl_rot_sel.sv
// rs_rot_sel: grants the first set request at or after ptr, wrapping modulo N
module rs_rot_sel #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         valid
);
  always_comb begin
    grant = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) grant = W'((int'(ptr) + i) % N);
  end
  assign valid = |req;
endmodule

// File: rtl/rs_ctrl.sv
// rs_ctrl: reservation-station slot allocation, CDB wakeup and rotating issue select
module rs_ctrl
  import sys_defs::*;
#(
  parameter int RS_SIZE = `RS_SIZE,
  parameter int TAG_W   = $clog2(`ROB_SIZE)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alloc_valid,
  input  logic [TAG_W-1:0]           alloc_rs1_tag,
  input  logic [TAG_W-1:0]           alloc_rs2_tag,
  input  logic                       alloc_rs1_ready,
  input  logic                       alloc_rs2_ready,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic                       ex_ready,
  input  logic                       squash,
  output logic                       alloc_ok,
  output logic [$clog2(RS_SIZE)-1:0] alloc_idx,
  output logic                       issue_valid,
  output logic [$clog2(RS_SIZE)-1:0] issue_idx,
  output logic [$clog2(RS_SIZE+1)-1:0] free_count
);
  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = $clog2(RS_SIZE + 1);
  RS_SLOT_STATE state [RS_SIZE];
  logic [TAG_W-1:0] tag1 [RS_SIZE];
  logic [TAG_W-1:0] tag2 [RS_SIZE];
  logic [RS_SIZE-1:0] pend1, pend2, np1, np2, free_v, ready_v;
  logic [IW-1:0] ptr;
  logic a_p1, a_p2;
  always_comb begin
    free_v = '0;
    ready_v = '0;
    np1 = '0;
    np2 = '0;
    free_count = '0;
    alloc_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      free_v[i] = state[i] == RS_FREE;
      ready_v[i] = state[i] == RS_READY;
      np1[i] = pend1[i] && !(cdb_valid && cdb_tag == tag1[i]);
      np2[i] = pend2[i] && !(cdb_valid && cdb_tag == tag2[i]);
      free_count = free_count + CW'(free_v[i]);
      if (free_v[i]) alloc_idx = IW'(i);
    end
  end
  assign alloc_ok = |free_v;
  // a same-cycle broadcast of the producer tag counts as already available
  assign a_p1 = !alloc_rs1_ready && !(cdb_valid && cdb_tag == alloc_rs1_tag);
  assign a_p2 = !alloc_rs2_ready && !(cdb_valid && cdb_tag == alloc_rs2_tag);
  rs_rot_sel #(.N(RS_SIZE), .W(IW)) u_sel (
    .req   (ready_v),
    .ptr   (ptr),
    .grant (issue_idx),
    .valid (issue_valid)
  );
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      ptr <= '0;
      pend1 <= '0;
      pend2 <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        state[i] <= RS_FREE;
        tag1[i] <= '0;
        tag2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RS_SIZE; i++)
        if (state[i] == RS_WAIT) begin
          pend1[i] <= np1[i];
          pend2[i] <= np2[i];
          if (!np1[i] && !np2[i]) state[i] <= RS_READY;
        end
      if (alloc_valid && alloc_ok) begin
        state[alloc_idx] <= (a_p1 || a_p2) ? RS_WAIT : RS_READY;
        tag1[alloc_idx] <= alloc_rs1_tag;
        tag2[alloc_idx] <= alloc_rs2_tag;
        pend1[alloc_idx] <= a_p1;
        pend2[alloc_idx] <= a_p2;
      end
      if (issue_valid && ex_ready) begin
        state[issue_idx] <= RS_FREE;
        ptr <= (issue_idx == IW'(RS_SIZE - 1)) ? '0 : issue_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rs_ctrl.sv
// tb_rs_ctrl: directed stimulus with a queue-based issue scoreboard for rs_ctrl
module tb_rs_ctrl;
  logic       clock = 0;
  logic       reset = 1;
  logic       alloc_valid = 0;
  logic [4:0] alloc_rs1_tag = 0, alloc_rs2_tag = 0;
  logic       alloc_rs1_ready = 0, alloc_rs2_ready = 0;
  logic       cdb_valid = 0;
  logic [4:0] cdb_tag = 0;
  logic       ex_ready = 0;
  logic       squash = 0;
  logic       alloc_ok, issue_valid;
  logic [2:0] alloc_idx, issue_idx;
  logic [3:0] free_count;
  int exp_q[$];
  int pass_n = 0, total_n = 0;

  rs_ctrl dut (
    .clock(clock), .reset(reset), .alloc_valid(alloc_valid),
    .alloc_rs1_tag(alloc_rs1_tag), .alloc_rs2_tag(alloc_rs2_tag),
    .alloc_rs1_ready(alloc_rs1_ready), .alloc_rs2_ready(alloc_rs2_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .ex_ready(ex_ready), .squash(squash),
    .alloc_ok(alloc_ok), .alloc_idx(alloc_idx), .issue_valid(issue_valid),
    .issue_idx(issue_idx), .free_count(free_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic alloc(input logic r1, input logic [4:0] t1, input logic r2, input logic [4:0] t2);
    alloc_valid = 1;
    alloc_rs1_ready = r1;
    alloc_rs1_tag = t1;
    alloc_rs2_ready = r2;
    alloc_rs2_tag = t2;
    tick;
    alloc_valid = 0;
  endtask

  task automatic issue(input int idx);
    exp_q.push_back(idx);
    ex_ready = 1;
    tick;
    ex_ready = 0;
  endtask

  // monitor: every accepted issue is matched against the next expected slot
  always @(negedge clock)
    if (!reset && !squash && issue_valid && ex_ready) begin
      if (exp_q.size() == 0) chk("issue_unexpected", int'(issue_idx), -1);
      else chk("issue_idx", int'(issue_idx), exp_q.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) tick;
    reset = 0;
    chk("rst_alloc_ok", alloc_ok, 1);
    chk("rst_alloc_idx", alloc_idx, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_idx", issue_idx, 0);
    chk("rst_free_count", free_count, 8);
    // basic alloc then issue
    alloc_valid = 1; alloc_rs1_ready = 1; alloc_rs2_ready = 1;
    chk("basic_alloc_idx", alloc_idx, 0);
    tick;
    alloc_valid = 0;
    chk("basic_issue_valid", issue_valid, 1);
    chk("basic_issue_idx", issue_idx, 0);
    chk("basic_free", free_count, 7);
    issue(0);
    chk("basic_free_after", free_count, 8);
    chk("basic_idle", issue_valid, 0);
    // wakeup two cycles after allocation
    alloc(0, 5, 1, 0);
    chk("wake_wait0", issue_valid, 0);
    tick;
    chk("wake_wait1", issue_valid, 0);
    cdb_valid = 1; cdb_tag = 5;
    chk("wake_bcast_cycle", issue_valid, 0);
    tick;
    cdb_valid = 0;
    chk("wake_ready", issue_valid, 1);
    chk("wake_idx", issue_idx, 0);
    issue(0);
    // bypass on same-cycle broadcast
    cdb_valid = 1; cdb_tag = 7;
    alloc(0, 7, 1, 0);
    cdb_valid = 0;
    chk("bypass_ready", issue_valid, 1);
    issue(0);
    // rs2 wakeup ignores a non-matching tag
    alloc(1, 0, 0, 3);
    cdb_valid = 1; cdb_tag = 4;
    tick;
    chk("rs2_nomatch", issue_valid, 0);
    cdb_tag = 3;
    tick;
    cdb_valid = 0;
    chk("rs2_match", issue_valid, 1);
    issue(0);
    // fill all slots, extra alloc ignored
    for (int i = 0; i < 8; i++) begin
      chk("fill_idx", alloc_idx, i);
      alloc(1, 0, 1, 0);
    end
    chk("full_alloc_ok", alloc_ok, 0);
    chk("full_free", free_count, 0);
    chk("full_alloc_idx", alloc_idx, 0);
    alloc(0, 9, 0, 9);
    chk("full_ignored", free_count, 0);
    // freed slot not reusable in the same cycle
    alloc_valid = 1; alloc_rs1_ready = 1; alloc_rs2_ready = 1;
    exp_q.push_back(1);
    ex_ready = 1;
    tick;
    alloc_valid = 0; ex_ready = 0;
    chk("free_alloc_ok", alloc_ok, 1);
    chk("free_alloc_idx", alloc_idx, 1);
    chk("free_count1", free_count, 1);
    // reset mid-operation wins over everything
    reset = 1; alloc_valid = 1; ex_ready = 1; cdb_valid = 1;
    tick;
    reset = 0; alloc_valid = 0; ex_ready = 0; cdb_valid = 0;
    chk("midrst_free", free_count, 8);
    chk("midrst_issue_valid", issue_valid, 0);
    // drive ptr to 4
    for (int i = 0; i < 4; i++) alloc(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) issue(i);
    // slots 0,3,7 ready, others wait on tag 9
    for (int i = 0; i < 8; i++) alloc((i == 0 || i == 3 || i == 7), 9, 1, 0);
    chk("rot_free", free_count, 0);
    chk("rot_first", issue_idx, 7);
    issue(7);
    issue(0);
    issue(3);
    chk("rot_idle", issue_valid, 0);
    chk("rot_free_after", free_count, 3);
    cdb_valid = 1; cdb_tag = 9;
    tick;
    cdb_valid = 0;
    chk("pre_squash_idx", issue_idx, 4);
    chk("pre_squash_free", free_count, 3);
    // squash with five busy slots plus alloc, issue and broadcast
    squash = 1; alloc_valid = 1; ex_ready = 1; cdb_valid = 1;
    tick;
    squash = 0; alloc_valid = 0; ex_ready = 0; cdb_valid = 0;
    chk("squash_free", free_count, 8);
    chk("squash_issue_valid", issue_valid, 0);
    chk("squash_alloc_ok", alloc_ok, 1);
    for (int i = 0; i < 6; i++) alloc(1, 0, 1, 0);
    chk("squash_ptr0", issue_idx, 0);
    for (int i = 0; i < 6; i++) issue(i);
    chk("final_free", free_count, 8);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
